// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target exposing a byte-wide register file to on-chip logic.
// All SPI pins are oversampled in the clk_i domain; nothing runs on SCK.
module spi_slave_regfile #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        spi_sck_i,
    input  logic                        spi_nss_i,
    input  logic                        spi_mosi_i,
    output logic                        spi_miso_o,
    output logic                        spi_miso_en_o,
    output logic [NUM_REGS*8-1:0]       regs_o,
    output logic                        wr_stb_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_e;

    // Synchronizers: bit 0 is the first stage, bit 2 the edge-detect stage.
    logic [2:0] sck_q;
    logic [2:0] nss_q;
    logic [1:0] mosi_q;
    logic [1:0] vld_q;
    logic       armed_q;

    state_e              state_q,   state_d;
    logic [2:0]          bitcnt_q,  bitcnt_d;
    logic [7:0]          rx_q,      rx_d;
    logic [7:0]          tx_q,      tx_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                wr_pend_q, wr_pend_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic                miso_q,    miso_d;
    logic                miso_en_q, miso_en_d;
    logic                wr_stb_q,  wr_stb_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          regs_q [NUM_REGS];

    logic       sck_rise;
    logic       sck_fall;
    logic       nss_fall;
    logic       nss_high;
    logic [7:0] rx_byte;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    // A fall only counts once NSS has really been seen high since reset,
    // so a transfer cut by reset is ignored until the next NSS fall.
    assign nss_fall = ~nss_q[1] & nss_q[2] & armed_q;
    assign nss_high = nss_q[1];
    assign rx_byte  = {rx_q[6:0], mosi_q[1]};

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_pend_d = 1'b0;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;

        if (nss_high) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (nss_fall) begin
                        state_d  = S_CMD;
                        bitcnt_d = 3'd0;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        rx_d     = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            addr_d  = rx_byte[ADDR_W-1:0];
                            tx_d    = 8'h00;
                            state_d = rx_byte[7] ? S_WDATA : S_RDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        rx_d     = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            wr_pend_d = 1'b1;
                            wr_data_d = rx_byte;
                            wr_ptr_d  = addr_q;
                            addr_d    = addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_RDATA: begin
                    if (sck_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else if (sck_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            tx_d   = regs_q[addr_q];
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        miso_en_d = (state_d == S_RDATA);
        miso_d    = miso_en_d & tx_d[7];
        wr_stb_d  = wr_pend_q;
        wr_addr_d = wr_pend_q ? wr_ptr_q : wr_addr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q     <= 3'b000;
            nss_q     <= 3'b111;
            mosi_q    <= 2'b00;
            vld_q     <= 2'b00;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_data_q <= 8'h00;
            wr_ptr_q  <= '0;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            sck_q     <= {sck_q[1:0], spi_sck_i};
            nss_q     <= {nss_q[1:0], spi_nss_i};
            mosi_q    <= {mosi_q[0], spi_mosi_i};
            vld_q     <= {vld_q[0], 1'b1};
            armed_q   <= armed_q | (vld_q[1] & nss_q[1]);
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_pend_q <= wr_pend_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            miso_q    <= miso_d;
            miso_en_q <= miso_en_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            if (wr_pend_q) begin
                regs_q[wr_ptr_q] <= wr_data_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs_q[g];
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_en_o = miso_en_q;
    assign wr_stb_o      = wr_stb_q;
    assign wr_addr_o     = wr_addr_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: a bit-banged mode-0 master drives
// the pins while a monitor pops expected writes/reads and compares.
module tb_spi_slave_regfile;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  sck;
    logic                  nss;
    logic                  mosi;
    logic                  miso;
    logic                  miso_en;
    logic [NUM_REGS*8-1:0] regs;
    logic                  wr_stb;
    logic [ADDR_W-1:0]     wr_addr;

    int checks = 0;
    int errors = 0;

    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    logic [7:0] act_rd [$];
    logic [7:0] wq     [$];
    logic [7:0] model  [NUM_REGS];

    spi_slave_regfile #(.NUM_REGS(NUM_REGS), .RST_VAL(8'h00)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck),
        .spi_nss_i     (nss),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_en_o (miso_en),
        .regs_o        (regs),
        .wr_stb_o      (wr_stb),
        .wr_addr_o     (wr_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or a read byte lands.
    initial begin
        wr_t        e;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (!miso_en && miso) begin
                    errors++;
                    $display("FAIL miso_idle: got 1 while disabled, expected 0 (t=%0t)", $time);
                end
            end
            if (wr_stb) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_stb: got strobe addr %0d, expected none (t=%0t)", wr_addr, $time);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(regs[8*int'(e.addr) +: 8]), 32'(e.data));
                end
            end
            while (act_rd.size() > 0) begin
                a = act_rd.pop_front();
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd: got %0h, expected no read (t=%0t)", a, $time);
                end else begin
                    check("rd_data", 32'(a), 32'(exp_rd.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Shift nbits MSB-first; samples MISO and checks the enable at each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, input logic exp_en,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            rx  = {rx[6:0], miso};
            check("miso_en", 32'(miso_en), 32'(exp_en));
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic sel();
        nss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic desel();
        repeat (4) @(negedge clk);
        nss = 1'b1;
        repeat (6) @(negedge clk);
        check("miso_en_off", 32'(miso_en), 32'd0);
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a0);
        logic [7:0]        rx;
        logic [ADDR_W-1:0] a;
        a = a0;
        sel();
        xfer(8'h80 | 8'(a0), 8, 1'b0, rx);
        while (wq.size() > 0) begin
            logic [7:0] d;
            d = wq.pop_front();
            exp_wr.push_back('{addr: a, data: d});
            model[a] = d;
            xfer(d, 8, 1'b0, rx);
            a = a + ADDR_W'(1);
        end
        desel();
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] a0, input int n);
        logic [7:0]        rx;
        logic [ADDR_W-1:0] a;
        a = a0;
        sel();
        xfer(8'(a0), 8, 1'b0, rx);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(model[a]);
            xfer(8'h00, 8, 1'b1, rx);
            act_rd.push_back(rx);
            a = a + ADDR_W'(1);
        end
        desel();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 32'(regs[8*i +: 8]), 32'(model[i]));
        end
    endtask

    initial begin
        logic [7:0] rx;
        rst  = 1'b1;
        sck  = 1'b0;
        nss  = 1'b1;
        mosi = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_en", 32'(miso_en), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_regs("rst");

        // Write burst then read back.
        wq.push_back(8'hA5);
        wq.push_back(8'h5A);
        write_burst(4'd3);
        read_burst(4'd3, 2);

        // Address wrap on write and on read.
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        write_burst(4'd15);
        read_burst(4'd15, 2);
        check_regs("wrap");

        // Abort after 5 data bits: no write, no strobe; next transfer is fine.
        sel();
        xfer(8'h82, 8, 1'b0, rx);
        xfer(8'hFF, 5, 1'b0, rx);
        desel();
        check("abort_reg2", 32'(regs[8*2 +: 8]), 32'h00);
        wq.push_back(8'h33);
        write_burst(4'd2);

        // Reset mid-data-byte with NSS held low; the rest must be ignored.
        sel();
        xfer(8'h81, 8, 1'b0, rx);
        xfer(8'hFF, 4, 1'b0, rx);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        xfer(8'hAA, 8, 1'b0, rx);
        xfer(8'h55, 8, 1'b0, rx);
        desel();
        check_regs("rstmid");
        read_burst(4'd0, 16);

        // Loopback of 16 random bytes.
        for (int i = 0; i < NUM_REGS; i++) wq.push_back(8'($urandom_range(0, 255)));
        write_burst(4'd0);
        read_burst(4'd0, 16);
        check_regs("loop");

        repeat (10) @(negedge clk);
        check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
